// File: rtl/nf10_upb_demux_pkg.sv
// rtl/nf10_upb_demux_pkg.sv - shared FSM encoding and mode constants for the packet demultiplexer
package nf10_upb_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int MODE_ROUTE    = 0;
  localparam int MODE_LOOPBACK = 1;

endpackage

// File: rtl/demux_route_select.sv
// rtl/demux_route_select.sv - combinational route mask from tuser: bitmask routing or mirrored loopback
module demux_route_select
  import nf10_upb_demux_pkg::*;
#(
  parameter int C_NUM_PORTS     = 4,
  parameter int C_INPORT_WIDTH  = 3,
  parameter int C_OUTPORT_WIDTH = 8,
  parameter int C_MODE          = MODE_ROUTE
) (
  input  logic [C_INPORT_WIDTH-1:0]  in_port,
  input  logic [C_OUTPORT_WIDTH-1:0] out_port,
  output logic [C_NUM_PORTS-1:0]     new_sel
);

  // Only one of the two tuser fields matters for a given mode.
  logic unused_bits;
  assign unused_bits = ^{in_port, out_port};

  always_comb begin
    new_sel = '0;
    if (C_MODE == MODE_LOOPBACK) begin
      // An in_port with no mirrored partner yields an empty mask and is dropped.
      for (int i = 0; i < C_NUM_PORTS; i++) begin
        if (int'(in_port) == C_NUM_PORTS - 1 - i) new_sel[i] = 1'b1;
      end
    end else begin
      new_sel = out_port[C_NUM_PORTS-1:0];
    end
  end

endmodule

// File: rtl/packet_demultiplexer.sv
// rtl/packet_demultiplexer.sv - packet-aware AXI-Stream demux with multicast, loopback and counted drops
module packet_demultiplexer
  import nf10_upb_demux_pkg::*;
#(
  parameter int C_NUM_PORTS           = 4,
  parameter int C_AXIS_DATA_WIDTH     = 256,
  parameter int C_PACKET_LENGTH_WIDTH = 14,
  parameter int C_INPORT_WIDTH        = 3,
  parameter int C_OUTPORT_WIDTH       = 8,
  parameter int C_MODE                = MODE_ROUTE,
  parameter int C_DROP_CNT_WIDTH      = 32
) (
  input  logic                                              axi_aclk,
  input  logic                                              axi_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]                      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]                    s_axis_tkeep,
  input  logic [C_PACKET_LENGTH_WIDTH-1:0]                  s_axis_tuser_packet_length,
  input  logic [C_INPORT_WIDTH-1:0]                         s_axis_tuser_in_port,
  input  logic [C_OUTPORT_WIDTH-1:0]                        s_axis_tuser_out_port,
  input  logic [C_INPORT_WIDTH-1:0]                         s_axis_tuser_in_vport,
  input  logic [C_OUTPORT_WIDTH-1:0]                        s_axis_tuser_out_vport,
  input  logic                                              s_axis_tvalid,
  output logic                                              s_axis_tready,
  input  logic                                              s_axis_tlast,
  output logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]        m_axis_tkeep,
  output logic [C_NUM_PORTS*C_PACKET_LENGTH_WIDTH-1:0]      m_axis_tuser_packet_length,
  output logic [C_NUM_PORTS*C_INPORT_WIDTH-1:0]             m_axis_tuser_in_port,
  output logic [C_NUM_PORTS*C_OUTPORT_WIDTH-1:0]            m_axis_tuser_out_port,
  output logic [C_NUM_PORTS*C_INPORT_WIDTH-1:0]             m_axis_tuser_in_vport,
  output logic [C_NUM_PORTS*C_OUTPORT_WIDTH-1:0]            m_axis_tuser_out_vport,
  output logic [C_NUM_PORTS-1:0]                            m_axis_tvalid,
  input  logic [C_NUM_PORTS-1:0]                            m_axis_tready,
  output logic [C_NUM_PORTS-1:0]                            m_axis_tlast,
  output logic [C_DROP_CNT_WIDTH-1:0]                       drop_count
);

  localparam int KW = C_AXIS_DATA_WIDTH / 8;

  state_t                 state;
  logic [C_NUM_PORTS-1:0] sel_r, done_r, new_sel, cur_sel, accepted, m_valid;
  logic                   s_ready, drop_beat, drop_done;

  demux_route_select #(
    .C_NUM_PORTS    (C_NUM_PORTS),
    .C_INPORT_WIDTH (C_INPORT_WIDTH),
    .C_OUTPORT_WIDTH(C_OUTPORT_WIDTH),
    .C_MODE         (C_MODE)
  ) u_route_select (
    .in_port (s_axis_tuser_in_port),
    .out_port(s_axis_tuser_out_port),
    .new_sel (new_sel)
  );

  // The route is only sampled from tuser on a first beat; later beats reuse sel_r.
  assign cur_sel   = (state == ST_IDLE) ? new_sel : sel_r;
  assign drop_beat = (state == ST_DROP) || ((state == ST_IDLE) && (new_sel == '0));
  assign drop_done = drop_beat && s_axis_tvalid && s_axis_tlast;

  always_comb begin
    m_valid  = '0;
    accepted = '0;
    s_ready  = 1'b0;
    if (axi_resetn) begin
      if (drop_beat) begin
        s_ready = 1'b1;
      end else begin
        // done_r masks ports that already took this beat so nothing is duplicated.
        m_valid  = {C_NUM_PORTS{s_axis_tvalid}} & cur_sel & ~done_r;
        accepted = done_r | (m_valid & m_axis_tready);
        s_ready  = s_axis_tvalid & (&(accepted | ~cur_sel));
      end
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = m_valid;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state      <= ST_IDLE;
      sel_r      <= '0;
      done_r     <= '0;
      drop_count <= '0;
    end else begin
      if ((state == ST_IDLE) && s_axis_tvalid) sel_r <= new_sel;
      if (drop_done && (drop_count != '1)) drop_count <= drop_count + C_DROP_CNT_WIDTH'(1);
      case (state)
        ST_DROP: begin
          if (s_axis_tvalid && s_axis_tlast) state <= ST_IDLE;
        end
        default: begin
          if (s_axis_tvalid) begin
            if (drop_beat) begin
              if (!s_axis_tlast) state <= ST_DROP;
            end else if (s_ready) begin
              done_r <= '0;
              state  <= s_axis_tlast ? ST_IDLE : ST_FWD;
            end else begin
              done_r <= done_r | accepted;
            end
          end
        end
      endcase
    end
  end

  for (genvar i = 0; i < C_NUM_PORTS; i++) begin : g_port
    assign m_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH]                 = s_axis_tdata;
    assign m_axis_tkeep[i*KW +: KW]                                               = s_axis_tkeep;
    assign m_axis_tuser_packet_length[i*C_PACKET_LENGTH_WIDTH +: C_PACKET_LENGTH_WIDTH] = s_axis_tuser_packet_length;
    assign m_axis_tuser_in_port[i*C_INPORT_WIDTH +: C_INPORT_WIDTH]               = s_axis_tuser_in_port;
    assign m_axis_tuser_out_port[i*C_OUTPORT_WIDTH +: C_OUTPORT_WIDTH]            = C_OUTPORT_WIDTH'(cur_sel);
    assign m_axis_tuser_in_vport[i*C_INPORT_WIDTH +: C_INPORT_WIDTH]              = s_axis_tuser_in_vport;
    assign m_axis_tuser_out_vport[i*C_OUTPORT_WIDTH +: C_OUTPORT_WIDTH]           = s_axis_tuser_out_vport;
    assign m_axis_tlast[i]                                                        = s_axis_tlast;
  end

endmodule

// File: tb/tb_packet_demultiplexer.sv
// tb/tb_packet_demultiplexer.sv - scoreboard bench for packet_demultiplexer in route and loopback modes
module tb_packet_demultiplexer;

  localparam int NP = 4, DW = 32, KW = 4, LW = 14, IW = 3, OW = 8, DCW = 4;
  localparam int SAT = (1 << DCW) - 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [LW-1:0] len;
    logic [IW-1:0] inp;
    logic [OW-1:0] outp;
    logic [IW-1:0] inv;
    logic [OW-1:0] outv;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [DW-1:0]    s_tdata [2];
  logic [KW-1:0]    s_tkeep [2];
  logic [LW-1:0]    s_len   [2];
  logic [IW-1:0]    s_inp   [2];
  logic [OW-1:0]    s_outp  [2];
  logic [IW-1:0]    s_inv   [2];
  logic [OW-1:0]    s_outv  [2];
  logic             s_tvalid[2];
  logic             s_tready[2];
  logic             s_tlast [2];
  logic [NP*DW-1:0] m_tdata [2];
  logic [NP*KW-1:0] m_tkeep [2];
  logic [NP*LW-1:0] m_len   [2];
  logic [NP*IW-1:0] m_inp   [2];
  logic [NP*OW-1:0] m_outp  [2];
  logic [NP*IW-1:0] m_inv   [2];
  logic [NP*OW-1:0] m_outv  [2];
  logic [NP-1:0]    m_tvalid[2];
  logic [NP-1:0]    m_tready[2];
  logic [NP-1:0]    m_tlast [2];
  logic [DCW-1:0]   drop_cnt[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    packet_demultiplexer #(
      .C_NUM_PORTS(NP), .C_AXIS_DATA_WIDTH(DW), .C_PACKET_LENGTH_WIDTH(LW),
      .C_INPORT_WIDTH(IW), .C_OUTPORT_WIDTH(OW), .C_MODE(g), .C_DROP_CNT_WIDTH(DCW)
    ) u_dut (
      .axi_aclk(clk), .axi_resetn(rst_n),
      .s_axis_tdata(s_tdata[g]), .s_axis_tkeep(s_tkeep[g]),
      .s_axis_tuser_packet_length(s_len[g]), .s_axis_tuser_in_port(s_inp[g]),
      .s_axis_tuser_out_port(s_outp[g]), .s_axis_tuser_in_vport(s_inv[g]),
      .s_axis_tuser_out_vport(s_outv[g]), .s_axis_tvalid(s_tvalid[g]),
      .s_axis_tready(s_tready[g]), .s_axis_tlast(s_tlast[g]),
      .m_axis_tdata(m_tdata[g]), .m_axis_tkeep(m_tkeep[g]),
      .m_axis_tuser_packet_length(m_len[g]), .m_axis_tuser_in_port(m_inp[g]),
      .m_axis_tuser_out_port(m_outp[g]), .m_axis_tuser_in_vport(m_inv[g]),
      .m_axis_tuser_out_vport(m_outv[g]), .m_axis_tvalid(m_tvalid[g]),
      .m_axis_tready(m_tready[g]), .m_axis_tlast(m_tlast[g]),
      .drop_count(drop_cnt[g])
    );
  end

  beat_t exp_q [2][NP][$];
  int    exp_drop [2];
  int    checks = 0, failures = 0;
  bit    rdy_rand = 1'b0;
  logic [NP-1:0] rdy_val = '1;

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_tready[0] = '1;
    m_tready[1] = '1;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) m_tready[d] = rdy_rand ? NP'($urandom) : rdy_val;
    end
  end

  // Monitor: every completed output handshake must match the oldest expected beat of that port.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        if (m_tvalid[d][p] && m_tready[d][p]) begin
          beat_t a, e;
          a.data = m_tdata[d][p*DW +: DW];
          a.keep = m_tkeep[d][p*KW +: KW];
          a.len  = m_len[d][p*LW +: LW];
          a.inp  = m_inp[d][p*IW +: IW];
          a.outp = m_outp[d][p*OW +: OW];
          a.inv  = m_inv[d][p*IW +: IW];
          a.outv = m_outv[d][p*OW +: OW];
          a.last = m_tlast[d][p];
          checks++;
          if (exp_q[d][p].size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat dut=%0d port=%0d actual=%h required=none", d, p, a);
          end else begin
            e = exp_q[d][p].pop_front();
            if (a !== e) begin
              failures++;
              $display("FAIL beat dut=%0d port=%0d actual=%h required=%h", d, p, a, e);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [NP-1:0] exp_route(input int d, input logic [IW-1:0] inp,
                                              input logic [OW-1:0] outp);
    if (d == 0) return outp[NP-1:0];
    if (int'(inp) < NP) return NP'(1 << (NP - 1 - int'(inp)));
    return '0;
  endfunction

  task automatic set_ready(input bit rnd, input logic [NP-1:0] val);
    rdy_rand = rnd;
    rdy_val  = val;
    @(posedge clk);
    #2;
  endtask

  task automatic drive_beat(input int d, input logic [OW-1:0] outp, input logic [IW-1:0] inp,
                            input logic last, input logic [NP-1:0] route);
    beat_t e;
    s_tdata[d]  = $urandom;
    s_tkeep[d]  = KW'($urandom);
    s_len[d]    = LW'($urandom);
    s_inp[d]    = inp;
    s_outp[d]   = outp;
    s_inv[d]    = IW'($urandom);
    s_outv[d]   = OW'($urandom);
    s_tlast[d]  = last;
    s_tvalid[d] = 1'b1;
    e = '{data: s_tdata[d], keep: s_tkeep[d], len: s_len[d], inp: inp, outp: OW'(route),
          inv: s_inv[d], outv: s_outv[d], last: last};
    for (int p = 0; p < NP; p++) if (route[p]) exp_q[d][p].push_back(e);
  endtask

  task automatic wait_hs(input int d, output int stalls);
    int n = 0;
    @(negedge clk);
    while (!s_tready[d] && n < 200) begin
      n++;
      @(negedge clk);
    end
    stalls = n;
    if (!s_tready[d]) begin
      checks++;
      failures++;
      $display("FAIL hs_timeout dut=%0d actual=stalled required=handshake", d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input int d, input int n, input logic [OW-1:0] outp0, outp1,
                             input logic [IW-1:0] inp0, inp1, input bit rnd, output int stalls);
    logic [NP-1:0] r;
    logic [OW-1:0] o;
    logic [IW-1:0] i;
    int st;
    r = exp_route(d, inp0, outp0);
    stalls = 0;
    for (int b = 0; b < n; b++) begin
      o = (b == 0) ? outp0 : (rnd ? OW'($urandom) : outp1);
      i = (b == 0) ? inp0  : (rnd ? IW'($urandom) : inp1);
      drive_beat(d, o, i, b == n - 1, r);
      wait_hs(d, st);
      stalls += st;
    end
    s_tvalid[d] = 1'b0;
    if (r == '0) exp_drop[d] = (exp_drop[d] == SAT) ? SAT : exp_drop[d] + 1;
    chk($sformatf("drop_count_d%0d", d), drop_cnt[d], exp_drop[d]);
  endtask

  initial begin
    int st;
    logic [OW-1:0] ro;
    for (int d = 0; d < 2; d++) begin
      s_tdata[d] = '0; s_tkeep[d] = '0; s_len[d] = '0; s_inp[d] = '0; s_outp[d] = 8'h01;
      s_inv[d] = '0; s_outv[d] = '0; s_tlast[d] = 1'b0; s_tvalid[d] = 1'b1;
      exp_drop[d] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", m_tvalid[0], 0);
    chk("reset_tready", s_tready[0], 0);
    chk("reset_drop0", drop_cnt[0], 0);
    chk("reset_drop1", drop_cnt[1], 0);
    s_tvalid[0] = 1'b0;
    s_tvalid[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_ready(1'b0, '1);

    // Unicast to port 2.
    send_packet(0, 3, 8'h04, 8'h04, 3'd0, 3'd0, 1'b0, st);
    chk("unicast_stalls", st, 0);

    // Multicast 0+2 with port 2 back-pressured for two cycles.
    set_ready(1'b0, 4'b1011);
    fork
      send_packet(0, 3, 8'h05, 8'h05, 3'd0, 3'd0, 1'b0, st);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("mcast_port0_done", m_tvalid[0][0], 0);
        chk("mcast_port2_wait", m_tvalid[0][2], 1);
        chk("mcast_tready_low", s_tready[0], 0);
        rdy_val = '1;
      end
    join
    chk("mcast_stalls", st, 2);

    // Unroutable packet must be swallowed without back-pressure.
    send_packet(0, 4, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, st);
    chk("drop_stalls", st, 0);

    // Loopback back-to-back, then a route change mid-packet.
    send_packet(1, 2, 8'h00, 8'h00, 3'd0, 3'd0, 1'b0, st);
    chk("loop0_stalls", st, 0);
    send_packet(1, 3, 8'h00, 8'h00, 3'd1, 3'd1, 1'b0, st);
    chk("loop1_stalls", st, 0);
    send_packet(0, 4, 8'h01, 8'h02, 3'd0, 3'd0, 1'b0, st);

    // Random traffic with random back-pressure on both modes.
    set_ready(1'b1, '1);
    for (int k = 0; k < 40; k++) begin
      ro = ($urandom_range(0, 3) == 0) ? {4'($urandom), 4'b0} : OW'($urandom);
      send_packet(0, $urandom_range(1, 4), ro, 8'h00, IW'($urandom), 3'd0, 1'b1, st);
      send_packet(1, $urandom_range(1, 4), OW'($urandom), 8'h00, IW'($urandom_range(0, 7)),
                  3'd0, 1'b1, st);
    end

    // Reset in the middle of beat 2 of a 4-beat packet.
    set_ready(1'b0, '1);
    drive_beat(0, 8'h02, 3'd0, 1'b0, 4'b0010);
    wait_hs(0, st);
    drive_beat(0, 8'h02, 3'd0, 1'b0, 4'b0010);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_tvalid", m_tvalid[0], 0);
    chk("midreset_tready", s_tready[0], 0);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) exp_q[d][p].delete();
      exp_drop[d] = 0;
    end
    s_tvalid[0] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postreset_drop0", drop_cnt[0], 0);
    chk("postreset_drop1", drop_cnt[1], 0);
    send_packet(0, 2, 8'h08, 8'h08, 3'd0, 3'd0, 1'b0, st);

    // Drive the drop counter into saturation.
    for (int k = 0; k < SAT + 4; k++) send_packet(0, 1, 8'hF0, 8'h00, 3'd0, 3'd0, 1'b0, st);

    repeat (5) @(posedge clk);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NP; p++)
        chk($sformatf("drained_d%0d_p%0d", d, p), exp_q[d][p].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_demultiplexer.md
Name: packet_demultiplexer

Overview:
- Parametrised packet-aware AXI-Stream demultiplexer between the input arbiter and the C_NUM_PORTS output queues.
- Takes the route from tuser on the first beat of each packet and holds it to tlast, so routing never changes mid-packet.
- Supports multicast (several bits set in out_port), a fixed loopback mode and counted dropping of unroutable packets.

Parameters:
C_NUM_PORTS, 4, number of output ports (1..8, ≤ C_OUTPORT_WIDTH)
C_AXIS_DATA_WIDTH, 256, tdata width; tkeep = C_AXIS_DATA_WIDTH/8
C_PACKET_LENGTH_WIDTH, 14, tuser packet_length width
C_INPORT_WIDTH, 3, tuser in_port/in_vport width
C_OUTPORT_WIDTH, 8, tuser out_port/out_vport width
C_MODE, 0, 0 = route by tuser_out_port bitmask; 1 = loopback, in_port i → port C_NUM_PORTS-1-i
C_DROP_CNT_WIDTH, 32, width of drop counter

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
s_axis_tdata  in  C_AXIS_DATA_WIDTH  input beat data
s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  byte enables
s_axis_tuser_packet_length  in  C_PACKET_LENGTH_WIDTH  packet length
s_axis_tuser_in_port  in  C_INPORT_WIDTH  ingress port index
s_axis_tuser_out_port  in  C_OUTPORT_WIDTH  destination bitmask
s_axis_tuser_in_vport  in  C_INPORT_WIDTH  virtual ingress port
s_axis_tuser_out_vport  in  C_OUTPORT_WIDTH  virtual destination
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat
m_axis_tdata  out  C_NUM_PORTS*C_AXIS_DATA_WIDTH  per-port data, port i in slice i
m_axis_tkeep  out  C_NUM_PORTS*C_AXIS_DATA_WIDTH/8  per-port tkeep
m_axis_tuser_packet_length  out  C_NUM_PORTS*C_PACKET_LENGTH_WIDTH  per-port length
m_axis_tuser_in_port  out  C_NUM_PORTS*C_INPORT_WIDTH  per-port in_port
m_axis_tuser_out_port  out  C_NUM_PORTS*C_OUTPORT_WIDTH  per-port effective route mask
m_axis_tuser_in_vport  out  C_NUM_PORTS*C_INPORT_WIDTH  per-port in_vport
m_axis_tuser_out_vport  out  C_NUM_PORTS*C_OUTPORT_WIDTH  per-port out_vport
m_axis_tvalid  out  C_NUM_PORTS  per-port valid
m_axis_tready  in  C_NUM_PORTS  per-port ready
m_axis_tlast  out  C_NUM_PORTS  per-port last
drop_count  out  C_DROP_CNT_WIDTH  packets dropped since reset, saturating

Behaviour:
- Interface clock/reset: single clock axi_aclk; axi_resetn asynchronous active-low.
- Datapath: combinational pass-through, zero latency. All data/tuser/tlast fields are broadcast to every slice. Exception: m_axis_tuser_out_port carries the effective route mask, zero-extended.
- Route computation (new_sel, C_NUM_PORTS bits):
  - Mode 0: out_port[C_NUM_PORTS-1:0].
  - Mode 1: one-hot(C_NUM_PORTS-1-in_port).
  - Mode 1 with in_port ≥ C_NUM_PORTS: new_sel = 0.
- FSM states IDLE, FWD, DROP; state register plus sel_r and done_r[C_NUM_PORTS].
  - cur_sel = new_sel in IDLE, else sel_r. sel_r loads new_sel every IDLE cycle with s_axis_tvalid.
  - IDLE, s_axis_tvalid, new_sel = 0: packet is dropped. s_axis_tready = 1. On the handshake go to DROP if !tlast, otherwise stay in IDLE and increment drop_count.
  - DROP: s_axis_tready = 1, all m_axis_tvalid = 0. Return to IDLE on the tlast handshake and increment drop_count there.
  - IDLE/FWD with cur_sel ≠ 0:
    - m_axis_tvalid[i] = s_axis_tvalid & cur_sel[i] & ~done_r[i].
    - accepted[i] = done_r[i] | (m_axis_tvalid[i] & m_axis_tready[i]).
    - s_axis_tready = s_axis_tvalid & &(accepted | ~cur_sel).
    - If some ports of the beat accepted but not all: done_r |= accepted.
    - When all accepted: done_r cleared.
    - On the beat handshake: if tlast go to IDLE, else go to FWD.
  - m_axis_tvalid never depends combinationally on its own m_axis_tready (AXI-compliant). A beat is delivered exactly once per selected port.
- drop_count saturates at all-ones.
- Reset values, and state during an asynchronous reset asserted mid-packet:
  - state IDLE; sel_r, done_r and drop_count 0.
  - All m_axis_tvalid 0 and s_axis_tready 0 while axi_resetn = 0.
  - A partially transferred packet is abandoned; no recovery.
- Back-to-back packets: the tlast beat and the next first beat may occur on consecutive cycles with no bubble.

Decomposition:
- Package nf10_upb_demux_pkg: state encoding (IDLE, FWD, DROP) and the mode constants MODE_ROUTE/MODE_LOOPBACK.
- One sub-module, demux_route_select: combinational new_sel from tuser and C_MODE, reusable by the testbench model.

Test Plan:
- Mode 0, C_NUM_PORTS = 4, out_port = 8'h04, 3-beat packet, all ready → only m_axis_tvalid[2] pulses for 3 cycles; tlast on beat 3; drop_count 0.
- Mode 0, out_port = 8'h05 multicast; port 0 ready, port 2 ready held low for 2 cycles → port 0 gets each beat once (done_r set); s_axis_tready low until port 2 accepts; no duplicate beats on either port.
- Mode 0, out_port = 8'h00, 4-beat packet → s_axis_tready = 1 throughout, no m_axis_tvalid, drop_count 0 → 1.
- Mode 1, in_port = 0 and in_port = 1 packets back-to-back → routed to port 3 then port 2 with no idle cycle; m_axis_tuser_out_port = 8'h08 / 8'h04.
- Change tuser_out_port mid-packet from 8'h01 to 8'h02 → all beats still on port 0.
- Assert axi_resetn low on beat 2 of a 4-beat packet → outputs invalid immediately; after release the next packet routes correctly and drop_count = 0.
